// File: rtl/hazard_scoreboard_pkg.sv
// Shared core definitions for the hazard scoreboard: FSM state encoding,
// forwarding-select width helper and long-latency opcode constants.
package hazard_scoreboard_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } hz_state_e;

  // Opcodes of instruction classes that retire through the long-latency path
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_MULDIV = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  function automatic int fw_width(input int nstg);
    return (nstg < 1) ? 1 : $clog2(nstg + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_regfile.sv
// Pending-write vector and outstanding long-latency counter.
module hazard_sb_regfile
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW     = 5,
  parameter int MAXOUT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_issue_long,
  input  logic [AW-1:0]     i_issue_rd,
  input  logic              i_wb_long,
  input  logic [AW-1:0]     i_wb_rd,
  output logic [2**AW-1:0]  o_pend,
  output logic              o_full
);

  localparam int CW = (MAXOUT > 0) ? $clog2(MAXOUT + 1) : 1;

  logic [2**AW-1:0] r_pend;
  logic [CW-1:0]    r_cnt;
  logic             w_inc;
  logic             w_dec;

  assign w_inc = i_issue_long;
  assign w_dec = i_wb_long && (r_cnt != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      // the set is written after the clear so it wins on the same register
      if (i_wb_long)
        r_pend[i_wb_rd] <= 1'b0;
      if (i_issue_long && (i_issue_rd != '0))
        r_pend[i_issue_rd] <= 1'b1;
      if (w_inc && !w_dec && (r_cnt != CW'(MAXOUT)))
        r_cnt <= r_cnt + 1'b1;
      else if (w_dec && !w_inc)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_pend = r_pend;
  assign o_full = (r_cnt == CW'(MAXOUT));

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, data-stall detection against
// stages and the long-latency scoreboard, trap flush FSM and stage control.
//
// state    | meaning
// ST_RUN   | normal operation, priority-ordered stall/bubble control
// ST_FLUSH | post-trap flush, all stages cleared, PC held
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW        = 5,
  parameter int NSTG      = 3,
  parameter int MAXOUT    = 4,
  parameter int FLUSH_CYC = 2,
  localparam int FW       = fw_width(NSTG)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AW-1:0]     rs1_id_i,
  input  logic [AW-1:0]     rs2_id_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  input  logic              issue_i,
  input  logic [AW-1:0]     issue_rd_i,
  input  logic              issue_long_i,
  input  logic              wb_valid_i,
  input  logic [AW-1:0]     wb_rd_i,
  input  logic              wb_long_i,
  input  logic [NSTG*AW-1:0] stage_rd_i,
  input  logic [NSTG-1:0]   stage_rdy_i,
  input  logic              redirect_i,
  input  logic              trap_i,
  input  logic              mem_busy_i,
  input  logic              if_busy_i,
  output logic [FW-1:0]     fw1_o,
  output logic [FW-1:0]     fw2_o,
  output logic [NSTG:0]     en_o,
  output logic [NSTG:0]     clear_o,
  output logic              pc_en_o,
  output logic              sb_full_o
);

  localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [NSTG:0] CTL_LAST = {{NSTG{1'b0}}, 1'b1};

  hz_state_e        r_state, w_state_nxt;
  logic [FCW-1:0]   r_fcnt, w_fcnt_nxt;
  logic [2**AW-1:0] w_pend;
  logic             w_full;
  logic [FW-1:0]    w_fw1, w_fw2;
  logic             w_hit1, w_hit2, w_rdy1, w_rdy2;
  logic             w_stall1, w_stall2, w_data_stall;

  hazard_sb_regfile #(
    .AW     (AW),
    .MAXOUT (MAXOUT)
  ) u_sb (
    .i_clk        (clk_i),
    .i_rst        (rst_i),
    .i_flush      (trap_i),
    .i_issue_long (issue_i && issue_long_i),
    .i_issue_rd   (issue_rd_i),
    .i_wb_long    (wb_valid_i && wb_long_i),
    .i_wb_rd      (wb_rd_i),
    .o_pend       (w_pend),
    .o_full       (w_full)
  );

  // walk oldest to youngest so the youngest matching stage wins
  always_comb begin
    w_fw1  = '0;
    w_fw2  = '0;
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_rdy1 = 1'b0;
    w_rdy2 = 1'b0;
    for (int k = NSTG; k >= 1; k--) begin
      if ((stage_rd_i[(k-1)*AW +: AW] != '0) && (stage_rd_i[(k-1)*AW +: AW] == rs1_id_i)) begin
        w_fw1  = FW'(k);
        w_hit1 = 1'b1;
        w_rdy1 = stage_rdy_i[k-1];
      end
      if ((stage_rd_i[(k-1)*AW +: AW] != '0) && (stage_rd_i[(k-1)*AW +: AW] == rs2_id_i)) begin
        w_fw2  = FW'(k);
        w_hit2 = 1'b1;
        w_rdy2 = stage_rdy_i[k-1];
      end
    end
  end

  assign w_stall1 = rs1_used_i && ((w_hit1 && !w_rdy1) || (w_pend[rs1_id_i] && !(w_hit1 && w_rdy1)));
  assign w_stall2 = rs2_used_i && ((w_hit2 && !w_rdy2) || (w_pend[rs2_id_i] && !(w_hit2 && w_rdy2)));
  assign w_data_stall = w_stall1 || w_stall2 || (issue_long_i && w_full);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      ST_RUN: begin
        if (trap_i) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = FCW'(FLUSH_CYC - 1);
        end
      end
      ST_FLUSH: begin
        if (trap_i)
          w_fcnt_nxt = FCW'(FLUSH_CYC - 1);
        else if (r_fcnt == '0)
          w_state_nxt = ST_RUN;
        else
          w_fcnt_nxt = r_fcnt - 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    en_o    = '1;
    clear_o = '0;
    pc_en_o = 1'b1;
    if (rst_i) begin
      clear_o = '1;
      pc_en_o = 1'b0;
    end else if (trap_i) begin
      clear_o = '1;
    end else if (r_state == ST_FLUSH) begin
      clear_o = '1;
      pc_en_o = 1'b0;
    end else if (mem_busy_i) begin
      en_o    = CTL_LAST;
      clear_o = CTL_LAST;
      pc_en_o = 1'b0;
    end else if (w_data_stall) begin
      en_o[NSTG]      = 1'b0;
      clear_o[NSTG-1] = 1'b1;
      pc_en_o         = 1'b0;
    end else if (redirect_i || if_busy_i) begin
      clear_o[NSTG] = 1'b1;
    end
  end

  assign fw1_o     = rst_i ? '0 : w_fw1;
  assign fw2_o     = rst_i ? '0 : w_fw2;
  assign sb_full_o = rst_i ? 1'b0 : w_full;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic, all compared against a behavioural model of the hazard rules.
module tb_hazard_scoreboard;

  localparam int AW = 5, NSTG = 3, MAXOUT = 4, FLUSH_CYC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, issue_rd = '0, wb_rd = '0;
  logic       rs1_used = 0, rs2_used = 0, issue = 0, issue_long = 0;
  logic       wb_valid = 0, wb_long = 0;
  logic       redirect = 0, trap = 0, mem_busy = 0, if_busy = 0;
  logic [4:0] st_rd [1:3];
  logic       st_rdy [1:3];
  logic [14:0] stage_rd_bus;
  logic [2:0]  stage_rdy_bus;

  logic [1:0] fw1, fw2;
  logic [3:0] en, clr;
  logic       pc_en, sb_full;

  assign stage_rd_bus  = {st_rd[3], st_rd[2], st_rd[1]};
  assign stage_rdy_bus = {st_rdy[3], st_rdy[2], st_rdy[1]};

  always #5 clk = ~clk;

  hazard_scoreboard #(.AW(AW), .NSTG(NSTG), .MAXOUT(MAXOUT), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk_i(clk), .rst_i(rst),
    .rs1_id_i(rs1), .rs2_id_i(rs2), .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
    .issue_i(issue), .issue_rd_i(issue_rd), .issue_long_i(issue_long),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_long_i(wb_long),
    .stage_rd_i(stage_rd_bus), .stage_rdy_i(stage_rdy_bus),
    .redirect_i(redirect), .trap_i(trap), .mem_busy_i(mem_busy), .if_busy_i(if_busy),
    .fw1_o(fw1), .fw2_o(fw2), .en_o(en), .clear_o(clr), .pc_en_o(pc_en), .sb_full_o(sb_full)
  );

  int n_chk = 0, n_pass = 0;

  // model state
  bit m_pend [32];
  int m_cnt = 0;
  int m_flush_left = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic find_fw(input logic [4:0] rs, output int k_hit, output bit rdy);
    k_hit = 0;
    rdy   = 0;
    for (int k = 1; k <= 3; k++)
      if (k_hit == 0 && st_rd[k] != 0 && st_rd[k] == rs) begin
        k_hit = k;
        rdy   = st_rdy[k];
      end
  endtask

  task automatic model_check(input string tag);
    int k1, k2;
    bit r1, r2, stall;
    int e_en, e_clr, e_pc;
    find_fw(rs1, k1, r1);
    find_fw(rs2, k2, r2);
    stall = 0;
    if (rs1_used && ((k1 != 0 && !r1) || (m_pend[rs1] && !(k1 != 0 && r1)))) stall = 1;
    if (rs2_used && ((k2 != 0 && !r2) || (m_pend[rs2] && !(k2 != 0 && r2)))) stall = 1;
    if (issue_long && m_cnt == MAXOUT) stall = 1;
    if (trap)                       begin e_en = 15; e_clr = 15; e_pc = 1; end
    else if (m_flush_left > 0)      begin e_en = 15; e_clr = 15; e_pc = 0; end
    else if (mem_busy)              begin e_en = 1;  e_clr = 1;  e_pc = 0; end
    else if (stall)                 begin e_en = 7;  e_clr = 4;  e_pc = 0; end
    else if (redirect || if_busy)   begin e_en = 15; e_clr = 8;  e_pc = 1; end
    else                            begin e_en = 15; e_clr = 0;  e_pc = 1; end
    check_eq({tag, ".fw1"}, fw1, k1);
    check_eq({tag, ".fw2"}, fw2, k2);
    check_eq({tag, ".en"}, en, e_en);
    check_eq({tag, ".clear"}, clr, e_clr);
    check_eq({tag, ".pc_en"}, pc_en, e_pc);
    check_eq({tag, ".sb_full"}, sb_full, (m_cnt == MAXOUT) ? 1 : 0);
  endtask

  task automatic model_update();
    bit li, lw;
    if (trap) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_cnt = 0;
      m_flush_left = FLUSH_CYC;
    end else begin
      if (m_flush_left > 0) m_flush_left--;
      if (wb_valid && wb_long) m_pend[wb_rd] = 0;
      if (issue && issue_long && issue_rd != 0) m_pend[issue_rd] = 1;
      li = issue && issue_long;
      lw = wb_valid && wb_long && m_cnt > 0;
      if (li && !lw && m_cnt < MAXOUT) m_cnt++;
      else if (lw && !li) m_cnt--;
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_cnt = 0;
    m_flush_left = 0;
  endtask

  // called at a negedge with inputs already driven
  task automatic step(input string tag);
    #1;
    model_check(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    issue = 0; issue_rd = 0; issue_long = 0;
    wb_valid = 0; wb_rd = 0; wb_long = 0;
    redirect = 0; trap = 0; mem_busy = 0; if_busy = 0;
    for (int k = 1; k <= 3; k++) begin st_rd[k] = 0; st_rdy[k] = 1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".en"}, en, 15);
    check_eq({tag, ".clear"}, clr, 15);
    check_eq({tag, ".pc_en"}, pc_en, 0);
    check_eq({tag, ".fw1"}, fw1, 0);
    check_eq({tag, ".fw2"}, fw2, 0);
    check_eq({tag, ".sb_full"}, sb_full, 0);
  endtask

  initial begin
    idle_inputs();
    rs1 = 5; st_rd[1] = 5;
    model_reset();
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 0;
    @(negedge clk);

    // forwarding from EX, then same with EX not ready
    idle_inputs();
    rs1 = 5; rs1_used = 1; st_rd[1] = 5; st_rdy[1] = 1;
    #1; check_eq("ex_fwd.fw1", fw1, 1); check_eq("ex_fwd.pc_en", pc_en, 1);
    step("ex_fwd");
    st_rdy[1] = 0;
    #1; check_eq("ex_nrdy.en", en, 4'b0111); check_eq("ex_nrdy.clear", clr, 4'b0100);
    step("ex_nrdy");

    // long issue then dependent read until writeback
    idle_inputs();
    issue = 1; issue_long = 1; issue_rd = 7;
    step("long7_issue");
    idle_inputs();
    rs2 = 7; rs2_used = 1;
    for (int i = 0; i < 3; i++) begin
      #1; check_eq("pend7_stall.pc_en", pc_en, 0);
      step("pend7_stall");
    end
    wb_valid = 1; wb_long = 1; wb_rd = 7;
    step("wb7");
    wb_valid = 0; wb_long = 0;
    #1; check_eq("after_wb7.pc_en", pc_en, 1);
    step("after_wb7");

    // fill scoreboard
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      issue = 1; issue_long = 1; issue_rd = 5'(i);
      step("fill");
    end
    idle_inputs();
    #1; check_eq("full.sb_full", sb_full, 1);
    issue_long = 1;
    #1; check_eq("full_long_id.pc_en", pc_en, 0);
    step("full_long_id");
    issue = 1; issue_long = 1; issue_rd = 8; wb_valid = 1; wb_long = 1; wb_rd = 1;
    step("full_issue_wb");
    idle_inputs();
    #1; check_eq("full_hold.sb_full", sb_full, 1);
    step("full_hold");

    // drain two, then trap with pending entries
    wb_valid = 1; wb_long = 1; wb_rd = 3; step("drain3");
    wb_rd = 4; step("drain4");
    idle_inputs();
    trap = 1; wb_valid = 1; wb_long = 1; wb_rd = 2;
    #1; check_eq("trap.pc_en", pc_en, 1); check_eq("trap.clear", clr, 15);
    step("trap");
    idle_inputs();
    #1; check_eq("flush1.pc_en", pc_en, 0); check_eq("flush1.clear", clr, 15);
    step("flush1");
    step("flush2");
    rs2 = 2; rs2_used = 1; rs1 = 8; rs1_used = 1;
    #1; check_eq("post_trap.pc_en", pc_en, 1); check_eq("post_trap.sb_full", sb_full, 0);
    step("post_trap");

    // trap while flushing extends the flush
    idle_inputs();
    trap = 1; step("trapA");
    trap = 1; step("trapB_in_flush");
    trap = 0;
    #1; check_eq("ext1.pc_en", pc_en, 0);
    step("ext1");
    #1; check_eq("ext2.pc_en", pc_en, 0);
    step("ext2");
    #1; check_eq("ext_done.pc_en", pc_en, 1);
    step("ext_done");

    // mem_busy beats redirect and data stall
    idle_inputs();
    mem_busy = 1; redirect = 1; rs1 = 5; rs1_used = 1; st_rd[1] = 5; st_rdy[1] = 0;
    #1; check_eq("membusy.en", en, 4'b0001); check_eq("membusy.clear", clr, 4'b0001);
    step("membusy");

    // reset in the middle of a flush
    idle_inputs();
    issue = 1; issue_long = 1; issue_rd = 9; step("pre_trap_issue");
    issue = 0; issue_long = 0; trap = 1; step("trapR");
    trap = 0; rs1 = 5; st_rd[1] = 5;
    rst = 1;
    #1; check_reset_outputs("rst_mid_flush");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    step("after_rst");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      rs1_used = 1'($urandom); rs2_used = 1'($urandom);
      for (int k = 1; k <= 3; k++) begin
        st_rd[k]  = 5'($urandom_range(0, 7));
        st_rdy[k] = ($urandom_range(0, 3) != 0);
      end
      issue = 1'($urandom); issue_long = ($urandom_range(0, 2) == 0);
      issue_rd = 5'($urandom_range(0, 7));
      wb_valid = ($urandom_range(0, 2) == 0); wb_long = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 7));
      trap = ($urandom_range(0, 19) == 0);
      mem_busy = ($urandom_range(0, 7) == 0);
      redirect = ($urandom_range(0, 5) == 0);
      if_busy = ($urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter AW, default 5: register-address width (2**AW registers).
REQ-002 SHALL have parameter NSTG, default 3: forwarding stages after ID (stage 1 = EX … stage NSTG = WB).
REQ-003 SHALL have parameter MAXOUT, default 4: maximum outstanding long-latency writes (load/CSR/mul/div).
REQ-004 SHALL have parameter FLUSH_CYC, default 2: cycles held in flush after a trap.
REQ-005 SHALL have clk_i  in  1: the only clock; reset is asynchronous and active-high; all state on rising edge.
REQ-006 SHALL have rst_i  in  1: asynchronous, active-high reset.
REQ-007 SHALL have rs1_id_i, rs2_id_i  in  AW each, plus rs1_used_i, rs2_used_i  in  1 each: ID source registers and use flags.
REQ-008 SHALL have issue_i  in  1, issue_rd_i  in  AW, issue_long_i  in  1: instruction leaves ID this cycle, its rd, and whether it is long-latency.
REQ-009 SHALL have wb_valid_i  in  1, wb_rd_i  in  AW, wb_long_i  in  1: long-latency result written to register file.
REQ-010 SHALL have stage_rd_i  in  NSTG*AW and stage_rdy_i  in  NSTG: per-stage rd (slice k-1 = stage k) and result-available flag.
REQ-011 SHALL have redirect_i, trap_i, mem_busy_i, if_busy_i  in  1 each: taken branch/jump in ID, exception, LS in MEM, fetch pending.
REQ-012 SHALL have fw1_o, fw2_o  out  clog2(NSTG+1) each: 0 = register file, k = stage k.
REQ-013 SHALL have en_o, clear_o  out  NSTG+1 each (bit NSTG = IF/ID, bit 0 = last register), pc_en_o  out  1, sb_full_o  out  1.

Function
REQ-014 SHALL select per source the lowest k with stage_rd[k]!=0 and == rs; fw=k; no match gives 0; computed combinationally.
REQ-015 SHALL raise a data stall if a used source matches its youngest stage k with stage_rdy[k]=0, or has its scoreboard pending bit set with no ready match.
REQ-016 SHALL keep a 2**AW-bit pending vector: on issue_i & issue_long_i & issue_rd!=0 set bit issue_rd; on wb_valid_i & wb_long_i clear bit wb_rd.
REQ-017 SHALL let set win over clear when issue and writeback target the same register in one cycle; register 0 is never set.
REQ-018 SHALL keep outstanding counter cnt (0..MAXOUT): +1 on long issue, -1 on long wb, unchanged if both; never below 0; wb with cnt=0 ignored.
REQ-019 SHALL drive sb_full_o=(cnt==MAXOUT), and treat a long-latency instruction in ID while sb_full_o as a data stall.
REQ-020 SHALL implement FSM RUN/FLUSH: trap_i in RUN -> FLUSH, counter loaded FLUSH_CYC-1; FLUSH -> RUN when counter 0; trap_i in FLUSH reloads the counter.
REQ-021 SHALL clear pending vector and cnt in the cycle trap_i is sampled; a same-cycle wb is discarded.
REQ-022 SHALL apply pipeline-control priority: trap/FLUSH > mem_busy > data stall > redirect > if_busy > normal.
REQ-023 SHALL on trap_i cycle: en all 1, clear all 1, pc_en 1; later FLUSH cycles: en all 1, clear all 1, pc_en 0.
REQ-024 SHALL on mem_busy_i: en=clear=1 at bit 0 only, pc_en 0.
REQ-025 SHALL on data stall: en all 1 except bit NSTG=0, clear only bit NSTG-1 (bubble), pc_en 0.
REQ-026 SHALL on redirect_i or if_busy_i: en all 1, clear only bit NSTG, pc_en 1; normal: en all 1, clear 0, pc_en 1.

Reset
REQ-027 SHALL on rst_i asynchronously force FSM RUN, flush counter 0, pending vector 0, cnt 0.
REQ-028 SHALL during reset drive en_o all 1, clear_o all 1, pc_en_o 0, fw1_o=fw2_o=0, sb_full_o 0.

Structure
REQ-029 SHALL take FSM state encoding, forwarding-select width function and the long-latency opcode constants from the shared core package.
REQ-030 SHALL place pending vector and counter in one sub-module, hazard_sb_regfile; forwarding, FSM and control stay in the top.

Verification
REQ-031 SHALL test: EX rd=5 rdy=1, rs1=5 -> fw1=1, no stall; same with rdy=0 -> en=4'b0111, clear=4'b0100, pc_en=0.
REQ-032 SHALL test: long issue rd=7, then rs2=7 with no stage match for 3 cycles -> stall each cycle; wb rd=7 -> stall drops next cycle.
REQ-033 SHALL test: 4 long issues (MAXOUT=4) -> sb_full_o=1, long op in ID stalls; issue+wb same cycle -> cnt stays 4.
REQ-034 SHALL test: trap_i with 2 pending -> pending/cnt 0, clear all 1 for 2 cycles, pc_en 1 then 0; trap in cycle 2 extends FLUSH 2 more cycles.
REQ-035 SHALL test: mem_busy_i with redirect_i and data stall -> en=clear=4'b0001, pc_en=0; rst_i mid-FLUSH -> RUN, outputs per REQ-028.
